// File: rtl/conf_shift_master_if.sv
// Bundle of pad-side and host-side signals for conf_shift_master.
// master: the shifter itself; slave: host logic plus pad/chain side.
interface conf_shift_master_if #(
  parameter int W = 256
);
  logic         START;
  logic [W-1:0] CONF_DATA;
  logic         BUSY;
  logic         DONE;
  logic         CLK_CONF;
  logic         SI_CONF;
  logic         LD_CONF;
  logic         DEF_CONF;
  logic         SO_CONF;
  logic [W-1:0] RB_DATA;
  logic         RB_MATCH;

  modport master (
    input  START, CONF_DATA, SO_CONF,
    output BUSY, DONE, CLK_CONF, SI_CONF,
    output LD_CONF, DEF_CONF, RB_DATA, RB_MATCH
  );

  modport slave (
    output START, CONF_DATA, SO_CONF,
    input  BUSY, DONE, CLK_CONF, SI_CONF,
    input  LD_CONF, DEF_CONF, RB_DATA, RB_MATCH
  );
endinterface

// File: rtl/conf_shift_master.sv
// Serial configuration chain master: shift word LSB-first, pulse load.
// Optional readback of old chain contents: CONF_SHIFT_MASTER_READBACK_EN.
module conf_shift_master #(
  parameter int CONF_WIDTH = 256,
  parameter int CLK_DIV    = 4,
  parameter int LD_GAP     = 1
) (
  input  logic CLK,
  input  logic RST_N,
  conf_shift_master_if.master bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SHIFT = 3'd1;
  localparam logic [2:0] S_GAP   = 3'd2;
  localparam logic [2:0] S_LOAD  = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;

  localparam int CW = $clog2(CONF_WIDTH + 1);
  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int GW = (LD_GAP > 0) ? $clog2(LD_GAP + 1) : 1;

  localparam logic [CW-1:0] BIT_LAST = CW'(CONF_WIDTH - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST =
    GW'((LD_GAP > 0) ? LD_GAP - 1 : 0);

  logic [2:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DW-1:0]         div_q, div_d;
  logic                  ph_q, ph_d;
  logic [GW-1:0]         gap_q, gap_d;
  logic [CONF_WIDTH-1:0] sh_q, sh_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  cc_q, cc_d;
  logic                  si_q, si_d;
  logic                  ld_q, ld_d;
  logic                  def_q, def_d;

  logic hend;
  logic pend;

`ifdef CONF_SHIFT_MASTER_READBACK_EN
  logic [CONF_WIDTH-1:0] cur_q, cur_d;
  logic [CONF_WIDTH-1:0] prev_q, prev_d;
  logic [CONF_WIDTH-1:0] acc_q, acc_d;
  logic [CONF_WIDTH-1:0] rb_q, rb_d;
  logic                  have_q, have_d;
  logic                  match_q, match_d;
`endif

  // ph_q is the bit-period phase: 0 = low half, 1 = high half
  assign hend = (div_q == DIV_LAST);
  assign pend = hend & ph_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    ph_d    = ph_q;
    gap_d   = gap_q;
    sh_d    = sh_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    si_d    = si_q;
    ld_d    = ld_q;
    def_d   = def_q;
`ifdef CONF_SHIFT_MASTER_READBACK_EN
    cur_d   = cur_q;
    prev_d  = prev_q;
    acc_d   = acc_q;
    rb_d    = rb_q;
    have_d  = have_q;
    match_d = match_q;
`endif

    if (state_q == S_SHIFT || state_q == S_GAP ||
        state_q == S_LOAD) begin
      if (hend) begin
        div_d = '0;
        ph_d  = ~ph_q;
      end else begin
        div_d = div_q + 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (bus.START) begin
          sh_d    = bus.CONF_DATA;
          si_d    = bus.CONF_DATA[0];
          cnt_d   = '0;
          div_d   = '0;
          ph_d    = 1'b0;
          gap_d   = '0;
          busy_d  = 1'b1;
          state_d = S_SHIFT;
`ifdef CONF_SHIFT_MASTER_READBACK_EN
          cur_d   = bus.CONF_DATA;
          acc_d   = '0;
`endif
        end
      end
      S_SHIFT: begin
`ifdef CONF_SHIFT_MASTER_READBACK_EN
        // chain has not shifted yet at this edge: SO is the oldest bit
        if (hend && !ph_q) begin
          acc_d = acc_q >> 1;
          acc_d[CONF_WIDTH-1] = bus.SO_CONF;
        end
`endif
        if (pend) begin
          if (cnt_q == BIT_LAST) begin
            state_d = (LD_GAP > 0) ? S_GAP : S_LOAD;
            ld_d    = (LD_GAP == 0);
            gap_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
            sh_d  = sh_q >> 1;
            si_d  = sh_d[0];
          end
        end
      end
      S_GAP: begin
        if (pend) begin
          if (gap_q == GAP_LAST) begin
            state_d = S_LOAD;
            ld_d    = 1'b1;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (pend) begin
          state_d = S_FIN;
          ld_d    = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          def_d   = 1'b0;
`ifdef CONF_SHIFT_MASTER_READBACK_EN
          rb_d    = acc_q;
          match_d = have_q && (acc_q == prev_q);
          prev_d  = cur_q;
          have_d  = 1'b1;
`endif
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    cc_d = (state_d == S_SHIFT) && ph_d;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      ph_q    <= 1'b0;
      gap_q   <= '0;
      sh_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cc_q    <= 1'b0;
      si_q    <= 1'b0;
      ld_q    <= 1'b0;
      def_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      ph_q    <= ph_d;
      gap_q   <= gap_d;
      sh_q    <= sh_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cc_q    <= cc_d;
      si_q    <= si_d;
      ld_q    <= ld_d;
      def_q   <= def_d;
    end
  end

`ifdef CONF_SHIFT_MASTER_READBACK_EN
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      cur_q   <= '0;
      prev_q  <= '0;
      acc_q   <= '0;
      rb_q    <= '0;
      have_q  <= 1'b0;
      match_q <= 1'b0;
    end else begin
      cur_q   <= cur_d;
      prev_q  <= prev_d;
      acc_q   <= acc_d;
      rb_q    <= rb_d;
      have_q  <= have_d;
      match_q <= match_d;
    end
  end

  assign bus.RB_DATA  = rb_q;
  assign bus.RB_MATCH = match_q;
`else
  logic unused_so;
  assign unused_so    = bus.SO_CONF;
  assign bus.RB_DATA  = '0;
  assign bus.RB_MATCH = 1'b0;
`endif

  assign bus.BUSY     = busy_q;
  assign bus.DONE     = done_q;
  assign bus.CLK_CONF = cc_q;
  assign bus.SI_CONF  = si_q;
  assign bus.LD_CONF  = ld_q;
  assign bus.DEF_CONF = def_q;

endmodule
